// File: rtl/bcd_scan_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter_if
// Groups the control and display signals of bcd_scan_counter into one bundle.
//
// Signals:
//   enable      1        prescaler runs and the counter steps while high
//   forward     1        1 = count up, 0 = count down
//   load        1        single-cycle request to load load_value
//   load_value  4*DIGITS packed BCD load value, digit 0 in bits [3:0]
//   a..g        1 each   segment drives, active-low
//   dp          1        decimal point, active-low (always off)
//   an          DIGITS   anode select, one-hot-low
//   wrap        1        single-cycle pulse on rollover/underflow/saturation
//
// Modports:
//   master  drives the controls and watches the display (bench / system)
//   slave   the counter itself
// -----------------------------------------------------------------------------
interface bcd_scan_counter_if #(
   parameter int DIGITS = 4
) ();
   logic                  enable;
   logic                  forward;
   logic                  load;
   logic [4*DIGITS-1:0]   load_value;
   logic                  a, b, c, d, e, f, g;
   logic                  dp;
   logic [DIGITS-1:0]     an;
   logic                  wrap;

   modport master (
      output enable, forward, load, load_value,
      input  a, b, c, d, e, f, g, dp, an, wrap
   );

   modport slave (
      input  enable, forward, load, load_value,
      output a, b, c, d, e, f, g, dp, an, wrap
   );
endinterface

// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
// Multi-digit BCD up/down counter with a prescaled step and a multiplexed
// seven-segment display scanner.
//
// Ports:
//   clk_100MHz  in   sole clock, everything on its rising edge
//   reset       in   synchronous, active-high
//   bus         slave modport of bcd_scan_counter_if (controls + display)
//
// Parameters:
//   DIGITS       number of BCD digits / anodes (1..8)
//   TICK_DIV     clock cycles per count step (>=2)
//   REFRESH_DIV  clock cycles per display digit slot (>=2)
//
// Build option:
//   BCD_SATURATE_EN  when defined, the count holds at all-9s (up) and all-0s
//                    (down) instead of wrapping; wrap still pulses.
// -----------------------------------------------------------------------------
module bcd_scan_counter #(
   parameter int DIGITS      = 4,
   parameter int TICK_DIV    = 100000000,
   parameter int REFRESH_DIV = 100000
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   bcd_scan_counter_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(REFRESH_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = 4 * DIGITS;

   logic [PW-1:0]     presc_q, presc_d;
   logic [SW-1:0]     scan_q, scan_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_inc, cnt_dec, load_bcd;
   logic              wrap_q, wrap_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic [3:0]        dig_sel;
   logic              all9, all0, carry, borrow, step, boundary;

   // Active-low abcdefg pattern for one hex digit.
   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0:    seg7 = 7'b0000001;
         4'h1:    seg7 = 7'b1001111;
         4'h2:    seg7 = 7'b0010010;
         4'h3:    seg7 = 7'b0000110;
         4'h4:    seg7 = 7'b1001100;
         4'h5:    seg7 = 7'b0100100;
         4'h6:    seg7 = 7'b0100000;
         4'h7:    seg7 = 7'b0001111;
         4'h8:    seg7 = 7'b0000000;
         4'h9:    seg7 = 7'b0000100;
         4'hA:    seg7 = 7'b0001000;
         4'hB:    seg7 = 7'b1100000;
         4'hC:    seg7 = 7'b0110001;
         4'hD:    seg7 = 7'b1000010;
         4'hE:    seg7 = 7'b0110000;
         default: seg7 = 7'b0111000;
      endcase
   endfunction

   // Loaded nibbles above 9 are not valid BCD; pin them to 9.
   function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
      clamp_bcd = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) clamp_bcd[4*i +: 4] = 4'd9;
      end
   endfunction

   // Ripple-carry increment and ripple-borrow decrement, one digit at a time.
   always_comb begin
      cnt_inc = cnt_q;
      cnt_dec = cnt_q;
      carry   = 1'b1;
      borrow  = 1'b1;
      all9    = 1'b1;
      all0    = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (cnt_q[4*i +: 4] != 4'd9) all9 = 1'b0;
         if (cnt_q[4*i +: 4] != 4'd0) all0 = 1'b0;
         if (carry) begin
            if (cnt_q[4*i +: 4] >= 4'd9) begin
               cnt_inc[4*i +: 4] = 4'd0;
            end else begin
               cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (cnt_q[4*i +: 4] == 4'd0) begin
               cnt_dec[4*i +: 4] = 4'd9;
            end else begin
               cnt_dec[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   assign load_bcd = clamp_bcd(bus.load_value);
   assign step     = bus.enable && (presc_q == PW'(TICK_DIV - 1));
   assign boundary = bus.forward ? all9 : all0;

   always_comb begin
      presc_d = presc_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      if (bus.load) begin
         // A load wins over a coincident step and restarts the prescale.
         presc_d = '0;
         cnt_d   = load_bcd;
      end else begin
         if (bus.enable) presc_d = step ? '0 : presc_q + PW'(1);
         if (step) begin
            wrap_d = boundary;
`ifdef BCD_SATURATE_EN
            if (!boundary) cnt_d = bus.forward ? cnt_inc : cnt_dec;
`else
            cnt_d = bus.forward ? cnt_inc : cnt_dec;
`endif
         end
      end
   end

   // Display scan runs independently of enable.
   always_comb begin
      scan_d = scan_q + SW'(1);
      idx_d  = idx_q;
      if (scan_q == SW'(REFRESH_DIV - 1)) begin
         scan_d = '0;
         idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
      dig_sel = cnt_q[3:0];
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) dig_sel = cnt_q[4*i +: 4];
      end
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = seg7(dig_sel);
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         presc_q <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         scan_q  <= '0;
         idx_q   <= '0;
         an_q    <= '1;
         seg_q   <= '1;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_q;
   assign bus.dp   = 1'b1;
   assign bus.an   = an_q;
   assign bus.wrap = wrap_q;

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits and anodes (legal 1..8).
REQ-002 SHALL have parameter TICK_DIV, default 100000000, clk_100MHz cycles per count step (>=2).
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, clk_100MHz cycles per display digit slot (>=2).
REQ-004 SHALL have port clk_100MHz  input  1  sole clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port enable  input  1  1 = prescaler runs and counter steps; 0 = count and prescaler frozen.
REQ-007 SHALL have port forward  input  1  1 = count up, 0 = count down; sampled on each step.
REQ-008 SHALL have port load  input  1  1-cycle request to load load_value.
REQ-009 SHALL have port load_value  input  4*DIGITS  packed BCD; digit 0 in bits [3:0].
REQ-010 SHALL have ports a,b,c,d,e,f,g  output  1 each  segment drives, active-low, registered.
REQ-011 SHALL have port dp  output  1  decimal point, active-low, registered.
REQ-012 SHALL have port an  output  DIGITS  one-hot-low anode select, registered.
REQ-013 SHALL have port wrap  output  1  1-cycle pulse on rollover/underflow or saturation hit.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 while enable=1, hold while enable=0, and assert internal step in the cycle it equals TICK_DIV-1, then return to 0.
REQ-015 On step with forward=1, count SHALL increment as decimal with ripple carry across all DIGITS (e.g. 0199 -> 0200).
REQ-016 On step with forward=0, count SHALL decrement with ripple borrow (e.g. 0200 -> 0199).
REQ-017 Default boundary: all-9s + up SHALL become all-0s; all-0s + down SHALL become all-9s; wrap pulses 1 in the following cycle.
REQ-018 load=1 SHALL replace count next cycle, override a coincident step and reset the prescaler to 0; any loaded nibble >9 SHALL be stored as 9.
REQ-019 Count update latency: step or load at cycle N, new value visible in count register at N+1, on segments by the next scan of that digit.
REQ-020 Scan counter SHALL count 0..REFRESH_DIV-1 regardless of enable; at terminal value digit index advances 0,1..DIGITS-1,0.
REQ-021 an SHALL drive only bit [index] low; segments SHALL show the hex-to-7-seg pattern of digit [index], both registered one cycle after index changes.
REQ-022 Segment patterns (abcdefg, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-023 dp SHALL be 1 (off) at all times.
REQ-024 forward change mid-prescale SHALL take effect at the next step only; no glitch steps.

Reset
REQ-025 reset=1 SHALL dominate load, step and enable in the same cycle.
REQ-026 After reset: count all 0, prescaler 0, scan counter 0, index 0, wrap 0, an all 1s, a..g all 1, dp 1.
REQ-027 First cycle after reset release: an[0]=0, segments show 0 (0000001).
REQ-028 reset mid-operation SHALL abandon any pending step or load; no wrap pulse emitted.

Configuration
REQ-029 Macro BCD_SATURATE_EN: when defined, up at all-9s and down at all-0s SHALL hold count unchanged and pulse wrap; when undefined, REQ-017 wrap-around applies.

Verification (DIGITS=4, TICK_DIV=4, REFRESH_DIV=2)
REQ-030 reset 3 cycles, release, enable=1, forward=1, 40 cycles -> count 0010, steps every 4 cycles, wrap never 1.
REQ-031 load 9998 (load_value=16'h9998), forward=1, 8 cycles -> 9999 then 0000, wrap pulses 1 cycle; with BCD_SATURATE_EN -> holds 9999, wrap pulses.
REQ-032 load 0000, forward=0, 4 cycles -> 9999 and wrap pulse; load 16'hFA3C -> stored 9939.
REQ-033 enable=0 for 20 cycles at count 0042 -> count stays 0042 while an keeps scanning 1110,1101,1011,0111 every 2 cycles.
REQ-034 count 0123, watch scan -> digit0 an=1110 seg 0000110, digit1 an=1101 seg 0010010, digit2 an=1011 seg 1001111, digit3 an=0111 seg 0000001.
REQ-035 assert reset coincident with load and step -> next cycle count 0000, wrap 0, an 1111, segments 1111111.
